// File: rtl/riscv_pkg.sv
// Shared integer-core types: data word, register index and ROB tag widths.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned NRP    = 2;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [TAG_W-1:0]  rob_tag_t;
  typedef logic [XLEN-1:0]   word_t;

  // One source-operand lookup result as seen by dispatch
  typedef struct packed {
    word_t    data;
    logic     busy;
    rob_tag_t tag;
  } rd_result_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered source-operand read port: x0 forcing, commit bypass,
// flush busy-masking, then a 1-cycle output register.
module reg_file_read_port
  import riscv_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     req_in,
  input  reg_idx_t addr_in,
  input  word_t    rf_data_in,
  input  logic     rf_busy_in,
  input  rob_tag_t rf_tag_in,
  input  logic     cmt_en_in,
  input  reg_idx_t cmt_rd_in,
  input  rob_tag_t cmt_tag_in,
  input  word_t    cmt_data_in,
  input  logic     flush_in,
  output logic     valid_out,
  output word_t    data_out,
  output logic     busy_out,
  output rob_tag_t tag_out
);

  rd_result_t res_c;
  logic       cmt_hit_c;

  // Lookup sees pre-rename state; a same-cycle commit is forwarded
  always_comb begin
    res_c     = '0;
    cmt_hit_c = cmt_en_in && (cmt_rd_in == addr_in);
    if (addr_in != '0) begin
      res_c.data = cmt_hit_c ? cmt_data_in : rf_data_in;
      res_c.tag  = rf_tag_in;
      res_c.busy = rf_busy_in && !flush_in &&
                   !(cmt_hit_c && (rf_tag_in == cmt_tag_in));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      busy_out  <= 1'b0;
      tag_out   <= '0;
    end else if (rdy_in) begin
      valid_out <= req_in;
      if (req_in) begin
        data_out <= res_c.data;
        busy_out <= res_c.busy;
        tag_out  <= res_c.tag;
      end
    end
  end

endmodule

// File: rtl/reg_file_tagged.sv
// Architectural register file with per-register rename state (busy + ROB tag),
// one rename and one commit per cycle, flush, and NRP registered read ports.
module reg_file_tagged
  import riscv_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [NRP-1:0]          rd_req_in,
  input  logic [NRP*REG_AW-1:0]   rd_addr_in,
  output logic [NRP-1:0]          rd_valid_out,
  output logic [NRP*XLEN-1:0]     rd_data_out,
  output logic [NRP-1:0]          rd_busy_out,
  output logic [NRP*TAG_W-1:0]    rd_tag_out,
  input  logic                    ren_en_in,
  input  reg_idx_t                ren_rd_in,
  input  rob_tag_t                ren_tag_in,
  input  logic                    cmt_en_in,
  input  reg_idx_t                cmt_rd_in,
  input  rob_tag_t                cmt_tag_in,
  input  word_t                   cmt_data_in,
  input  logic                    flush_in
);

  word_t           rf_data [NREG];
  rob_tag_t        rf_tag  [NREG];
  logic [NREG-1:0] rf_busy;

  logic            cmt_wr_c;
  logic            cmt_clr_c;
  logic            ren_wr_c;
  logic [NREG-1:0] busy_nxt_c;

  // Busy update order: commit clear, then rename set, then flush clears all
  always_comb begin
    cmt_wr_c   = cmt_en_in && (cmt_rd_in != '0);
    ren_wr_c   = ren_en_in && (ren_rd_in != '0) && !flush_in;
    cmt_clr_c  = cmt_wr_c && rf_busy[cmt_rd_in] &&
                 (rf_tag[cmt_rd_in] == cmt_tag_in) &&
                 !(ren_en_in && (ren_rd_in == cmt_rd_in));
    busy_nxt_c = rf_busy;
    if (cmt_clr_c) busy_nxt_c[cmt_rd_in] = 1'b0;
    if (ren_wr_c)  busy_nxt_c[ren_rd_in] = 1'b1;
    if (flush_in)  busy_nxt_c = '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_data[i] <= '0;
        rf_tag[i]  <= '0;
      end
      rf_busy <= '0;
    end else if (rdy_in) begin
      if (cmt_wr_c) rf_data[cmt_rd_in] <= cmt_data_in;
      if (ren_wr_c) rf_tag[ren_rd_in]  <= ren_tag_in;
      rf_busy <= busy_nxt_c;
    end
  end

  for (genvar p = 0; p < int'(NRP); p++) begin : g_port
    reg_idx_t addr_c;
    assign addr_c = rd_addr_in[p*REG_AW +: REG_AW];

    reg_file_read_port u_port (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .req_in      (rd_req_in[p]),
      .addr_in     (addr_c),
      .rf_data_in  (rf_data[addr_c]),
      .rf_busy_in  (rf_busy[addr_c]),
      .rf_tag_in   (rf_tag[addr_c]),
      .cmt_en_in   (cmt_en_in),
      .cmt_rd_in   (cmt_rd_in),
      .cmt_tag_in  (cmt_tag_in),
      .cmt_data_in (cmt_data_in),
      .flush_in    (flush_in),
      .valid_out   (rd_valid_out[p]),
      .data_out    (rd_data_out[p*XLEN +: XLEN]),
      .busy_out    (rd_busy_out[p]),
      .tag_out     (rd_tag_out[p*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_reg_file_tagged.sv
// Self-checking bench for reg_file_tagged: directed vector table, random traffic
// against an array-based reference model, and an asynchronous mid-run reset.
module tb_reg_file_tagged;
  import riscv_pkg::*;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  rdy_in;
  logic [NRP-1:0]        rd_req_in;
  logic [NRP*REG_AW-1:0] rd_addr_in;
  logic [NRP-1:0]        rd_valid_out;
  logic [NRP*XLEN-1:0]   rd_data_out;
  logic [NRP-1:0]        rd_busy_out;
  logic [NRP*TAG_W-1:0]  rd_tag_out;
  logic                  ren_en_in;
  reg_idx_t              ren_rd_in;
  rob_tag_t              ren_tag_in;
  logic                  cmt_en_in;
  reg_idx_t              cmt_rd_in;
  rob_tag_t              cmt_tag_in;
  word_t                 cmt_data_in;
  logic                  flush_in;

  reg_file_tagged dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in),
    .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
    .rd_busy_out(rd_busy_out), .rd_tag_out(rd_tag_out),
    .ren_en_in(ren_en_in), .ren_rd_in(ren_rd_in), .ren_tag_in(ren_tag_in),
    .cmt_en_in(cmt_en_in), .cmt_rd_in(cmt_rd_in), .cmt_tag_in(cmt_tag_in),
    .cmt_data_in(cmt_data_in), .flush_in(flush_in)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural values plus rename state per register
  logic [31:0] m_data [32];
  logic        m_busy [32];
  int          m_tag  [32];
  // Expected registered outputs per port
  logic        e_valid [2];
  logic [31:0] e_data  [2];
  logic        e_busy  [2];
  int          e_tag   [2];

  typedef struct {
    logic        rdy;
    logic [1:0]  req;
    int          a0, a1;
    logic        ren;
    int          rrd, rtag;
    logic        cmt;
    int          crd, ctag;
    logic [31:0] cdat;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        eb;
    int          et;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s port%0d: got %h, expected %h", nm, p, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = 0;
    end
    for (int p = 0; p < 2; p++) begin
      e_valid[p] = 1'b0;
      e_data[p]  = '0;
      e_busy[p]  = 1'b0;
      e_tag[p]   = 0;
    end
  endtask

  task automatic check_ports(input string nm);
    for (int p = 0; p < 2; p++) begin
      chk({nm, ".valid"}, p, 32'(rd_valid_out[p]), 32'(e_valid[p]));
      chk({nm, ".data"}, p, rd_data_out[p*XLEN +: XLEN], e_data[p]);
      chk({nm, ".busy"}, p, 32'(rd_busy_out[p]), 32'(e_busy[p]));
      if (e_busy[p])
        chk({nm, ".tag"}, p, 32'(rd_tag_out[p*TAG_W +: TAG_W]), 32'(e_tag[p]));
    end
  endtask

  // Drive one cycle, predict from the model, advance the model, then compare
  task automatic cycle(input logic rdy, input logic [1:0] req, input int a0, input int a1,
                       input logic ren, input int rrd, input int rtag,
                       input logic cmt, input int crd, input int ctag, input logic [31:0] cdat,
                       input logic fl, input string nm);
    int a;
    rdy_in      = rdy;
    rd_req_in   = req;
    rd_addr_in  = {REG_AW'(a1), REG_AW'(a0)};
    ren_en_in   = ren;
    ren_rd_in   = REG_AW'(rrd);
    ren_tag_in  = TAG_W'(rtag);
    cmt_en_in   = cmt;
    cmt_rd_in   = REG_AW'(crd);
    cmt_tag_in  = TAG_W'(ctag);
    cmt_data_in = cdat;
    flush_in    = fl;
    if (rdy) begin
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? a0 : a1;
        e_valid[p] = req[p];
        if (req[p]) begin
          if (a == 0) begin
            e_data[p] = '0; e_busy[p] = 1'b0; e_tag[p] = 0;
          end else begin
            e_data[p] = (cmt && crd == a) ? cdat : m_data[a];
            e_busy[p] = m_busy[a] && !fl && !(cmt && crd == a && m_tag[a] == ctag);
            e_tag[p]  = m_tag[a];
          end
        end
      end
      if (cmt && crd != 0) begin
        m_data[crd] = cdat;
        if (m_busy[crd] && m_tag[crd] == ctag && !(ren && rrd == crd)) m_busy[crd] = 1'b0;
      end
      if (ren && rrd != 0 && !fl) begin
        m_busy[rrd] = 1'b1;
        m_tag[rrd]  = rtag;
      end
      if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end
    @(posedge clk_in);
    #1;
    check_ports(nm);
  endtask

  function automatic vec_t mk(input logic rdy, input logic [1:0] req, input int a0, input int a1,
                              input logic ren, input int rrd, input int rtag,
                              input logic cmt, input int crd, input int ctag, input logic [31:0] cdat,
                              input logic fl, input logic ev, input logic [31:0] ed,
                              input logic eb, input int et);
    vec_t v;
    v.rdy = rdy; v.req = req; v.a0 = a0; v.a1 = a1;
    v.ren = ren; v.rrd = rrd; v.rtag = rtag;
    v.cmt = cmt; v.crd = crd; v.ctag = ctag; v.cdat = cdat; v.fl = fl;
    v.ev = ev; v.ed = ed; v.eb = eb; v.et = et;
    return v;
  endfunction

  initial begin
    int a0, a1, rrd, crd, ctag;
    logic ren, cmt, fl, rdy;
    logic [1:0] req;

    // Directed scenarios; expected columns are port-0 outputs after the edge
    tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 0, 32'h0, 0, 0);
    tbl[1]  = mk(1, 2'b11, 5, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[2]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
    tbl[3]  = mk(1, 2'b00, 0, 0, 1, 7, 2, 0, 0, 0, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 1, 2);
    tbl[5]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 7, 2, 32'h11, 0, 0, 32'h0, 1, 2);
    tbl[6]  = mk(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h11, 0, 0);
    tbl[7]  = mk(1, 2'b00, 0, 0, 1, 7, 2, 0, 0, 0, 32'h0, 0, 0, 32'h11, 0, 0);
    tbl[8]  = mk(1, 2'b00, 0, 0, 1, 7, 5, 0, 0, 0, 32'h0, 0, 0, 32'h11, 0, 0);
    tbl[9]  = mk(1, 2'b01, 7, 0, 0, 0, 0, 1, 7, 2, 32'h22, 0, 1, 32'h22, 1, 5);
    tbl[10] = mk(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h22, 1, 5);
    tbl[11] = mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 9, 0, 32'h33, 0, 0, 32'h22, 1, 5);
    tbl[12] = mk(1, 2'b01, 9, 0, 1, 9, 4, 0, 0, 0, 32'h0, 0, 1, 32'h33, 0, 0);
    tbl[13] = mk(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h33, 1, 4);
    tbl[14] = mk(1, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 32'h33, 1, 4);
    tbl[15] = mk(1, 2'b00, 0, 0, 1, 2, 6, 0, 0, 0, 32'h0, 0, 0, 32'h33, 1, 4);
    tbl[16] = mk(1, 2'b11, 1, 2, 1, 4, 7, 1, 3, 0, 32'h44, 1, 1, 32'h0, 0, 0);
    tbl[17] = mk(1, 2'b11, 3, 4, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h44, 0, 0);
    tbl[18] = mk(1, 2'b11, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
    tbl[19] = mk(1, 2'b01, 0, 0, 1, 0, 9, 1, 0, 0, 32'hFF, 0, 1, 32'h0, 0, 0);
    tbl[20] = mk(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
    tbl[21] = mk(0, 2'b11, 5, 9, 1, 5, 3, 1, 5, 0, 32'h55, 0, 1, 32'h0, 0, 0);
    tbl[22] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
    tbl[23] = mk(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[24] = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);

    rst_in = 1'b1; rdy_in = 1'b0; rd_req_in = '0; rd_addr_in = '0;
    ren_en_in = 1'b0; ren_rd_in = '0; ren_tag_in = '0;
    cmt_en_in = 1'b0; cmt_rd_in = '0; cmt_tag_in = '0; cmt_data_in = '0; flush_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_ports("reset");
    rst_in = 1'b0;

    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].rdy, tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].ren, tbl[i].rrd, tbl[i].rtag,
            tbl[i].cmt, tbl[i].crd, tbl[i].ctag, tbl[i].cdat, tbl[i].fl, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.valid", i), 0, 32'(rd_valid_out[0]), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.data", i), 0, rd_data_out[XLEN-1:0], tbl[i].ed);
      chk($sformatf("tbl%0d.busy", i), 0, 32'(rd_busy_out[0]), 32'(tbl[i].eb));
      if (tbl[i].eb)
        chk($sformatf("tbl%0d.tag", i), 0, 32'(rd_tag_out[TAG_W-1:0]), 32'(tbl[i].et));
    end

    // Random traffic over a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      rdy  = ($urandom_range(0, 9) != 0);
      req  = 2'($urandom_range(0, 3));
      a0   = int'($urandom_range(0, 7));
      a1   = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, 7));
      ren  = 1'($urandom_range(0, 1));
      rrd  = int'($urandom_range(0, 7));
      cmt  = 1'($urandom_range(0, 1));
      crd  = ($urandom_range(0, 2) == 0) ? a0 : int'($urandom_range(0, 7));
      ctag = ($urandom_range(0, 1) == 1) ? m_tag[crd] : int'($urandom_range(0, 15));
      fl   = ($urandom_range(0, 19) == 0);
      cycle(rdy, req, a0, a1, ren, rrd, int'($urandom_range(0, 15)),
            cmt, crd, ctag, $urandom, fl, "rand");
    end

    // Asynchronous reset mid-operation drops a pending valid immediately
    cycle(1, 2'b11, 5, 6, 1, 6, 3, 1, 5, 0, 32'hCAFE0001, 0, "pre_rst");
    #2;
    rdy_in = 1'b0;
    rst_in = 1'b1;
    #1;
    model_reset();
    check_ports("async_rst");
    @(negedge clk_in);
    rst_in = 1'b0;
    cycle(1, 2'b11, 5, 6, 0, 0, 0, 0, 0, 0, 32'h0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
